// File: rtl/mux_nx1_pipe_pkg.sv
// mux_pipe_pkg: shared elaboration helpers for the pipelined N:1 bit selector.
//   num_stages      - number of register stages for a given select width and
//                     number of 2:1 levels per stage.
//   stage_in_width  - width of the data vector entering stage k.
//   stage_levels    - number of 2:1 levels reduced inside stage k (the last
//                     stage may be short).
`timescale 1ns/1ps
package mux_pipe_pkg;

    function automatic int num_stages(input int sel_w, input int lvls);
        return (sel_w + lvls - 1) / lvls;
    endfunction

    function automatic int stage_in_width(input int sel_w, input int lvls, input int k);
        return (1 << sel_w) >> (k * lvls);
    endfunction

    function automatic int stage_levels(input int sel_w, input int lvls, input int k);
        int rem;
        rem = sel_w - k * lvls;
        return (rem < lvls) ? rem : lvls;
    endfunction

endpackage

// File: rtl/mux_nx1_pipe_if.sv
// mux_nx1_pipe_if: sample/result bundle of the pipelined N:1 bit selector.
//   in[N-1:0]      parallel data bus (N = 2**SEL_W)
//   sel            index of the bit to forward
//   in_valid       qualifier for in/sel
//   out            selected bit, registered
//   out_valid      one-cycle pulse per accepted sample
//   out_sel        select value that produced out
// master drives samples and observes results; slave is the selector.
`timescale 1ns/1ps
interface mux_nx1_pipe_if #(
    parameter int SEL_W = 10
);
    localparam int N = 1 << SEL_W;

    logic [N-1:0]     in;
    logic [SEL_W-1:0] sel;
    logic             in_valid;
    logic             out;
    logic             out_valid;
    logic [SEL_W-1:0] out_sel;

    modport master (
        output in, sel, in_valid,
        input  out, out_valid, out_sel
    );

    modport slave (
        input  in, sel, in_valid,
        output out, out_valid, out_sel
    );
endinterface

// File: rtl/mux_nx1_pipe_stage.sv
// mux_pipe_stage: one registered slice of the 2:1 reduction tree.
// Reduces IN_W inputs by a factor of 2**L using the low L bits of the
// remaining select; the consumed bits are shifted out for the next stage.
//   clk, rst       rising-edge clock, synchronous active-high reset
//   valid_i        sample qualifier; data/select fields load only when high
//   data_i         data vector entering this stage
//   sel_rem_i      unconsumed select bits (LSB-aligned)
//   sel_full_i     original select, carried for out_sel
//   valid_o, data_o, sel_rem_o, sel_full_o  registered stage outputs
`timescale 1ns/1ps
module mux_pipe_stage #(
    parameter int IN_W  = 4,
    parameter int L     = 2,
    parameter int SEL_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic [IN_W-1:0]        data_i,
    input  logic [SEL_W-1:0]       sel_rem_i,
    input  logic [SEL_W-1:0]       sel_full_i,
    output logic                   valid_o,
    output logic [(IN_W>>L)-1:0]   data_o,
    output logic [SEL_W-1:0]       sel_rem_o,
    output logic [SEL_W-1:0]       sel_full_o
);
    localparam int OUT_W = IN_W >> L;
    localparam int GRP   = 1 << L;
    localparam int IW    = $clog2(IN_W);

    logic [OUT_W-1:0] data_d, data_q;
    logic [SEL_W-1:0] sel_rem_d, sel_rem_q;
    logic [SEL_W-1:0] sel_full_d, sel_full_q;
    logic             valid_d, valid_q;

    // L cascaded 2:1 levels driven by sel bits 0..L-1 pick element
    // sel[L-1:0] out of each aligned group of 2**L inputs, so the group
    // base plus the low select bits addresses the surviving input directly.
    always_comb begin
        logic [IW-1:0] idx;
        idx        = '0;
        data_d     = data_q;
        sel_rem_d  = sel_rem_q;
        sel_full_d = sel_full_q;
        valid_d    = valid_i;
        if (valid_i) begin
            for (int i = 0; i < OUT_W; i++) begin
                idx       = IW'(i * GRP) | IW'(sel_rem_i[L-1:0]);
                data_d[i] = data_i[idx];
            end
            sel_rem_d  = sel_rem_i >> L;
            sel_full_d = sel_full_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            sel_rem_q  <= '0;
            sel_full_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            data_q     <= data_d;
            sel_rem_q  <= sel_rem_d;
            sel_full_q <= sel_full_d;
            valid_q    <= valid_d;
        end
    end

    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign sel_rem_o  = sel_rem_q;
    assign sel_full_o = sel_full_q;

endmodule

// File: rtl/mux_nx1_pipe.sv
// mux_nx1_pipe: pipelined N:1 bit selector (N = 2**SEL_W). The 2:1 tree is
// cut into S = ceil(SEL_W / LVLS_PER_STAGE) register stages; valid and select
// travel with each sample so one sample per clock streams through.
// A sample accepted at edge t appears on the outputs after edge t+S-1.
//   clk, rst   rising-edge clock, synchronous active-high reset
//   scan_en    (MUX_SCAN_EN builds only) use the internal scan counter as
//              select; the counter advances on each accepted sample
//   bus        mux_nx1_pipe_if slave: in/sel/in_valid -> out/out_valid/out_sel
// Optional feature macro: MUX_SCAN_EN.
`timescale 1ns/1ps
module mux_nx1_pipe
    import mux_pipe_pkg::*;
#(
    parameter int SEL_W          = 10,
    parameter int LVLS_PER_STAGE = 2
) (
    input logic           clk,
    input logic           rst,
`ifdef MUX_SCAN_EN
    input logic           scan_en,
`endif
    mux_nx1_pipe_if.slave bus
);
    localparam int S = num_stages(SEL_W, LVLS_PER_STAGE);

    logic [SEL_W-1:0] sel_src;

`ifdef MUX_SCAN_EN
    logic [SEL_W-1:0] scan_cnt_d, scan_cnt_q;

    // Exactly SEL_W bits wide, so N-1 rolls over to 0 on its own.
    always_comb begin
        scan_cnt_d = scan_cnt_q;
        if (scan_en && bus.in_valid) begin
            scan_cnt_d = scan_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
        end
    end

    assign sel_src = scan_en ? scan_cnt_q : bus.sel;
`else
    assign sel_src = bus.sel;
`endif

    for (genvar k = 0; k < S; k++) begin : g_stage
        localparam int IN_W = stage_in_width(SEL_W, LVLS_PER_STAGE, k);
        localparam int L    = stage_levels(SEL_W, LVLS_PER_STAGE, k);

        logic                 valid_i;
        logic [IN_W-1:0]      data_i;
        logic [SEL_W-1:0]     sel_rem_i;
        logic [SEL_W-1:0]     sel_full_i;
        logic                 valid_o;
        logic [(IN_W>>L)-1:0] data_o;
        logic [SEL_W-1:0]     sel_rem_o;
        logic [SEL_W-1:0]     sel_full_o;

        if (k == 0) begin : g_head
            assign valid_i    = bus.in_valid;
            assign data_i     = bus.in;
            assign sel_rem_i  = sel_src;
            assign sel_full_i = sel_src;
        end else begin : g_body
            assign valid_i    = g_stage[k-1].valid_o;
            assign data_i     = g_stage[k-1].data_o;
            assign sel_rem_i  = g_stage[k-1].sel_rem_o;
            assign sel_full_i = g_stage[k-1].sel_full_o;
        end

        mux_pipe_stage #(
            .IN_W  (IN_W),
            .L     (L),
            .SEL_W (SEL_W)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .valid_i    (valid_i),
            .data_i     (data_i),
            .sel_rem_i  (sel_rem_i),
            .sel_full_i (sel_full_i),
            .valid_o    (valid_o),
            .data_o     (data_o),
            .sel_rem_o  (sel_rem_o),
            .sel_full_o (sel_full_o)
        );

        // Every select bit has been consumed by the final stage.
        if (k == S - 1) begin : g_tail
            logic [SEL_W-1:0] sel_rem_unused;
            assign sel_rem_unused = sel_rem_o;
        end
    end

    assign bus.out       = g_stage[S-1].data_o[0];
    assign bus.out_valid = g_stage[S-1].valid_o;
    assign bus.out_sel   = g_stage[S-1].sel_full_o;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// tb_mux_nx1_pipe: directed bench for mux_nx1_pipe (SEL_W = 10, 2 levels per
// stage, so 5 stages). Inputs change and outputs are sampled on the falling
// edge; a sample driven at one falling edge shows up 5 falling edges later.
`timescale 1ns/1ps
module tb_mux_nx1_pipe;
    localparam int SEL_W = 10;
    localparam int N     = 1 << SEL_W;
    localparam int S     = 5;

    logic clk;
    logic rst;
`ifdef MUX_SCAN_EN
    logic scan_en;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mux_nx1_pipe_if #(.SEL_W(SEL_W)) bus ();

    mux_nx1_pipe #(
        .SEL_W          (SEL_W),
        .LVLS_PER_STAGE (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef MUX_SCAN_EN
        .scan_en (scan_en),
`endif
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]     din;
        logic [SEL_W-1:0] sel;
        logic             exp_out;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic ev, input logic eo,
                       input logic [SEL_W-1:0] es);
        n_tests++;
        if ({bus.out_valid, bus.out, bus.out_sel} !== {ev, eo, es}) begin
            n_fail++;
            $display("FAIL %s @%0t: got valid=%0b out=%0b sel=%0d, expected valid=%0b out=%0b sel=%0d",
                     name, $time, bus.out_valid, bus.out, bus.out_sel, ev, eo, es);
        end
    endtask

    logic [N-1:0]     rin, rin2, vin;
    logic             prev_out;
    logic [SEL_W-1:0] prev_sel;
    logic [SEL_W-1:0] ms_sel[10];
    logic             gv[5];
    logic [SEL_W-1:0] gsel[5];
    logic             gexp_v[6];
    logic             gexp_o[6];
    logic [SEL_W-1:0] gexp_s[6];

    initial begin
        rst          = 1'b1;
        bus.in       = '0;
        bus.sel      = '0;
        bus.in_valid = 1'b0;
`ifdef MUX_SCAN_EN
        scan_en      = 1'b0;
`endif

        // ---- reset state, samples during reset are dropped ----
        repeat (2) @(negedge clk);
        chk("reset_state", 1'b0, 1'b0, 10'd0);
        bus.in       = '1;
        bus.sel      = 10'd3;
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_hold", 1'b0, 1'b0, 10'd0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("reset_drop", 1'b0, 1'b0, 10'd0);
        end

        // ---- single sample: in = 1<<700, sel = 700 ----
        bus.in       = '0;
        bus.in[700]  = 1'b1;
        bus.sel      = 10'd700;
        bus.in_valid = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (c < S)       chk("single_lat", 1'b0, 1'b0, 10'd0);
            else if (c == S) chk("single_out", 1'b1, 1'b1, 10'd700);
            else             chk("single_hold", 1'b0, 1'b1, 10'd700);
        end
        prev_out = 1'b1;
        prev_sel = 10'd700;

        // ---- table-driven single samples incl. boundaries ----
        for (int i = 0; i < 8; i++) vecs[i].din = '0;
        vecs[0].din[0]    = 1'b1;  vecs[0].sel = 10'd0;    vecs[0].exp_out = 1'b1;
        vecs[1].din[1023] = 1'b1;  vecs[1].sel = 10'd1023; vecs[1].exp_out = 1'b1;
        vecs[2].din = '1; vecs[2].din[1023] = 1'b0; vecs[2].sel = 10'd1023; vecs[2].exp_out = 1'b0;
        vecs[3].din = '1; vecs[3].din[0]    = 1'b0; vecs[3].sel = 10'd0;    vecs[3].exp_out = 1'b0;
        vecs[4].din[1]    = 1'b1;  vecs[4].sel = 10'd1;    vecs[4].exp_out = 1'b1;
        vecs[5].din[512]  = 1'b1;  vecs[5].sel = 10'd512;  vecs[5].exp_out = 1'b1;
        vecs[6].din[512]  = 1'b1;  vecs[6].sel = 10'd511;  vecs[6].exp_out = 1'b0;
        for (int b = 0; b < N; b += 2) vecs[7].din[b+1] = 1'b1;
        vecs[7].sel = 10'd341;     vecs[7].exp_out = 1'b1;

        for (int i = 0; i < 8; i++) begin
            bus.in       = vecs[i].din;
            bus.sel      = vecs[i].sel;
            bus.in_valid = 1'b1;
            for (int c = 1; c <= 6; c++) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                if (c < S)       chk($sformatf("vec%0d_lat", i), 1'b0, prev_out, prev_sel);
                else if (c == S) chk($sformatf("vec%0d_out", i), 1'b1, vecs[i].exp_out, vecs[i].sel);
                else             chk($sformatf("vec%0d_hold", i), 1'b0, vecs[i].exp_out, vecs[i].sel);
            end
            prev_out = vecs[i].exp_out;
            prev_sel = vecs[i].sel;
        end

        // ---- streaming sweep sel = 0..1023 ----
        for (int w = 0; w < N / 32; w++) rin[w*32 +: 32] = $urandom;
        for (int c = 0; c <= 1029; c++) begin
            if (c >= S && c <= 1028)
                chk("sweep", 1'b1, rin[SEL_W'(c - S)], SEL_W'(c - S));
            else if (c < S)
                chk("sweep_pre", 1'b0, prev_out, prev_sel);
            else
                chk("sweep_post", 1'b0, rin[1023], 10'd1023);
            if (c < N) begin
                bus.in       = rin;
                bus.sel      = SEL_W'(c);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end

        // ---- reset mid-stream after the 3rd output ----
        for (int w = 0; w < N / 32; w++) rin2[w*32 +: 32] = $urandom;
        for (int k = 0; k < 10; k++) ms_sel[k] = SEL_W'(k * 97 + 13);
        for (int c = 0; c <= 15; c++) begin
            if (c < S)
                chk("midrst_pre", 1'b0, rin[1023], 10'd1023);
            else if (c <= 7 || c == 13 || c == 14)
                chk("midrst_out", 1'b1, rin2[ms_sel[c-S]], ms_sel[c-S]);
            else if (c <= 12)
                chk("midrst_flush", 1'b0, 1'b0, 10'd0);
            else
                chk("midrst_hold", 1'b0, rin2[ms_sel[9]], ms_sel[9]);
            rst = (c == 7);
            if (c < 10) begin
                bus.in       = rin2;
                bus.sel      = ms_sel[c];
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        rst = 1'b0;

        // ---- gapped valid 1,0,0,1,1 ----
        vin = '0;
        vin[100] = 1'b1;
        vin[300] = 1'b1;
        vin[555] = 1'b1;
        gv[0] = 1'b1; gv[1] = 1'b0; gv[2] = 1'b0; gv[3] = 1'b1; gv[4] = 1'b1;
        gsel[0] = 10'd100; gsel[1] = 10'd555; gsel[2] = 10'd555;
        gsel[3] = 10'd200; gsel[4] = 10'd300;
        gexp_v[0] = 1'b1; gexp_o[0] = 1'b1; gexp_s[0] = 10'd100;
        gexp_v[1] = 1'b0; gexp_o[1] = 1'b1; gexp_s[1] = 10'd100;
        gexp_v[2] = 1'b0; gexp_o[2] = 1'b1; gexp_s[2] = 10'd100;
        gexp_v[3] = 1'b1; gexp_o[3] = 1'b0; gexp_s[3] = 10'd200;
        gexp_v[4] = 1'b1; gexp_o[4] = 1'b1; gexp_s[4] = 10'd300;
        gexp_v[5] = 1'b0; gexp_o[5] = 1'b1; gexp_s[5] = 10'd300;
        for (int c = 0; c <= 10; c++) begin
            if (c < S)
                chk("gap_pre", 1'b0, rin2[ms_sel[9]], ms_sel[9]);
            else
                chk($sformatf("gap_%0d", c - S), gexp_v[c-S], gexp_o[c-S], gexp_s[c-S]);
            bus.in = vin;
            if (c < 5) begin
                bus.sel      = gsel[c];
                bus.in_valid = gv[c];
            end else begin
                bus.sel      = 10'd555;
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end

`ifdef MUX_SCAN_EN
        // ---- scan counter: 1026 consecutive samples ----
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int w = 0; w < N / 32; w++) rin[w*32 +: 32] = $urandom;
        for (int c = 0; c <= 1031; c++) begin
            if (c < S)
                chk("scan_pre", 1'b0, 1'b0, 10'd0);
            else if (c <= 1030)
                chk("scan", 1'b1, rin[SEL_W'(c - S)], SEL_W'(c - S));
            else
                chk("scan_post", 1'b0, rin[1], 10'd1);
            bus.in  = rin;
            bus.sel = 10'd7;
            if (c < 1026) begin
                scan_en      = 1'b1;
                bus.in_valid = 1'b1;
            end else begin
                scan_en      = 1'b0;
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_nx1_pipe.md
# mux_nx1_pipe

Pipelined N-to-1 selector (N = 2**SEL_W) that gathers one bit out of a wide parallel bus onto a single registered output. It is the collecting counterpart of the registered 1-to-N demux tree and sits on the return path of the same I/O-register stress benchmarks. The 2:1 reduction tree is cut into register stages. A valid bit and the select value travel with each sample, so back-to-back samples stream at one per clock.

## Interface
Parameters:
- SEL_W, 10: select width; N = 2**SEL_W inputs.
- LVLS_PER_STAGE, 2: number of 2:1 tree levels between pipeline registers; legal range 1..SEL_W.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  reset, synchronous and active-high.
- in  input  N  parallel data bus.
- sel  input  SEL_W  index of the bit to forward.
- in_valid  input  1  sample qualifier for in/sel.
- out  output  1  selected bit, registered.
- out_valid  output  1  high for one cycle per accepted sample.
- out_sel  output  SEL_W  sel value that produced the current out.
- scan_en  input  1  exists only with MUX_SCAN_EN; enables the auto-select mode.

## Operation
- Pipeline stages: S = ceil(SEL_W / LVLS_PER_STAGE).
  - Stage k reduces its data vector by levels k·LVLS_PER_STAGE up to (k+1)·LVLS_PER_STAGE−1.
  - Level j uses sel bit j; tree level 0 pairs adjacent inputs (2i, 2i+1) using sel[0].
  - The last stage may contain fewer levels.
- Each stage register holds the following:
  - the reduced data vector;
  - the remaining (unconsumed) sel bits;
  - the full original sel, used for out_sel;
  - a valid bit.
- Valid bits load every cycle from the previous stage; stage 0 loads from in_valid.
- Data, sel and out_sel fields load only when the incoming valid is 1; otherwise they hold.
  - Consequence: out and out_sel hold the last valid result while out_valid is 0.
- For any sample with sel = s, out equals in[s] as sampled on the in_valid cycle.
- There is no backpressure; every accepted sample emerges exactly once.

## Timing
- Latency: a sample accepted at edge t appears on out/out_valid/out_sel after edge t+S−1. Defaults give S = 5.
- Throughput: one sample per cycle. Consecutive valid samples emerge on consecutive cycles in order.
- Reset:
  - While rst is high at an edge, every stage register clears: data 0, sel 0, valid 0.
  - Reset values are out = 0, out_valid = 0, out_sel = 0.
  - Samples presented during reset are dropped.
  - Asserting rst mid-stream discards all in-flight samples; nothing partial emerges after release.
  - The first sample accepted on the first edge with rst low appears S cycles later.
- Boundaries:
  - sel = 0 selects in[0]; sel = N−1 selects in[N−1].
  - in_valid toggling every cycle yields an out_valid pattern identical to it, shifted by S.

## Configuration
- With MUX_SCAN_EN undefined:
  - the scan_en port is absent;
  - stage 0 uses the sel port directly.
- With MUX_SCAN_EN defined, an internal SEL_W-bit scan counter is added:
  - Reset value is 0.
  - It increments on every edge where scan_en && in_valid, wrapping from N−1 to 0.
  - While scan_en = 1, stage 0 uses the counter value in place of sel; out_sel reports the counter value.
  - While scan_en = 0, the sel port is used and the counter holds.
  - The wrap needs no special case, because the counter is exactly SEL_W bits wide.

## Structure
- Package mux_pipe_pkg contains:
  - a function computing S from SEL_W and LVLS_PER_STAGE;
  - a function computing the data width at the input of stage k (N >> (k·LVLS_PER_STAGE)).
- Sub-module mux_pipe_stage: one registered stage that reduces by 2**L inputs. Its parameters are input width and L.
- The top generates S instances of mux_pipe_stage plus the optional scan counter.

## Test plan
- Reset and single sample:
  - After reset, out/out_valid/out_sel are 0.
  - Drive in = 1<<700, sel = 700, in_valid = 1 for one cycle.
  - Expect out = 1, out_sel = 700 and out_valid pulse exactly 5 cycles later, then out_valid = 0 with out held at 1.
- Streaming sweep:
  - Drive sel = 0..1023 on consecutive cycles with a random in held constant.
  - Expect out_valid high for 1024 consecutive cycles and out = in[sel] each cycle, in order.
- Boundaries:
  - sel = 0 with in = 1 gives out = 1.
  - sel = 1023 with in = 1<<1023 gives out = 1.
  - sel = 1023 with in = ~(1<<1023) gives out = 0.
- Reset mid-stream:
  - Stream 10 samples, assert rst for 1 cycle after the 3rd output.
  - Expect no further out_valid until new samples are accepted, with outputs 0 until then.
- Gapped valid:
  - Use the in_valid pattern 1,0,0,1,1.
  - Expect the same out_valid pattern shifted by 5, with out/out_sel held during the gaps.
- MUX_SCAN_EN build:
  - scan_en = 1 with in_valid = 1 for 1026 cycles.
  - Expect out_sel to run 0..1023, 0, 1 and out to track in[out_sel].
